ram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that sits directly upstream of the 64x8 simple dual-port RAM (one write port, one registered read port).
- Converts a push/pop stream interface into RAM write-enable, write address, write data and read address.
- Re-aligns the RAM's one-cycle registered read data with a valid strobe.
- Tying both RAM clocks to the same clk makes read-after-write ordering deterministic.

---
 rtl/ram_fifo_ctrl_pkg.sv | 12 +
 rtl/ram_fifo_ctrl_if.sv | 44 ++++
 rtl/ram_fifo_ctrl.sv | 96 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the FIFO controller and the 64x8 simple dual-port RAM
// it drives. The RAM uses the same defaults, so keeping them in one package
// stops the controller and the memory from disagreeing on geometry.
package ram_fifo_ctrl_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 6;
  localparam int DEPTH_DEF    = 1 << ADDR_W_DEF;
  localparam int AF_LEVEL_DEF = 56;
  localparam int AE_LEVEL_DEF = 8;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream interface of the RAM FIFO controller.
//
// Handshake: there is no ready signal. A push is accepted in a cycle where
// push=1 and full=0; a pop is accepted where pop=1 and empty=0, both judged
// on the state before the clock edge. A rejected request is reported by a
// one-cycle overflow/underflow pulse after the edge. dout carries the popped
// word in the cycle after an accepted pop, marked by dout_valid.
//
// Modports:
//   master : the user side (drives push/din/pop, observes data and status)
//   slave  : the controller side
interface ram_fifo_ctrl_if
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              push;
  logic [DATA_W-1:0] din;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, din, pop,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, din, pop,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a single-clock simple dual-port RAM with a registered
// read port. It turns the push/pop stream into RAM write/read controls and
// re-aligns the RAM's one-cycle read data with a valid strobe. The controller
// holds no storage itself; the RAM lives outside.
//
// Ports:
//   clk, rst   : clock (also clocks the RAM), synchronous active-high reset
//   bus        : push/pop stream, status flags and error pulses (slave side)
//   ram_we     : RAM write enable (an accepted push)
//   ram_waddr  : RAM write address (write pointer)
//   ram_wdata  : RAM write data (din passthrough)
//   ram_raddr  : RAM read address (read pointer, sampled by RAM every edge)
//   ram_rdata  : RAM registered read data, forwarded to dout
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              dout_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full_c;
  logic              empty_c;
  logic              push_ok;
  logic              pop_ok;

  assign full_c  = (count_q == DEPTH_C);
  assign empty_c = (count_q == '0);

  // Empty blocks a same-cycle pop of a word being pushed, so a word is read
  // at the earliest one edge after its write has committed: no bypass path.
  assign push_ok = bus.push & ~full_c;
  assign pop_ok  = bus.pop  & ~empty_c;

  assign ram_we    = push_ok;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = bus.din;
  assign ram_raddr = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      // Pointers wrap naturally at DEPTH because they are exactly ADDR_W wide.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // The RAM registers its read on the same edge that accepts the pop,
      // so the valid strobe is simply the pop acceptance delayed one cycle.
      dout_valid_q <= pop_ok;
      overflow_q   <= bus.push & full_c;
      underflow_q  <= bus.pop  & empty_c;
    end
  end

  assign bus.dout         = ram_rdata;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl. A behavioural 64x8 RAM with a
// registered read sits on the RAM port. A reference occupancy/pointer model
// predicts status, and a scoreboard queue holds every accepted push until the
// matching word appears on dout with dout_valid.
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int DEPTH = DEPTH_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  ram_fifo_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF_LEVEL_DEF), .AE_LEVEL(AE_LEVEL_DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // Behavioural RAM: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  int            m_count;
  int            m_wr;
  int            m_rd;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. Called just after a negedge; checks the
  // combinational RAM controls before the edge and all registered outputs
  // on the following negedge.
  task automatic step(input logic r, input logic p, input logic [DW-1:0] d, input logic q);
    logic push_ok, pop_ok, exp_valid, exp_ovf, exp_unf;
    logic [DW-1:0] exp_d;
    rst = r; bus.push = p; bus.din = d; bus.pop = q;
    #1;
    push_ok   = p && (m_count < DEPTH);
    pop_ok    = q && (m_count > 0);
    exp_ovf   = !r && p && (m_count == DEPTH);
    exp_unf   = !r && q && (m_count == 0);
    exp_valid = !r && pop_ok;
    if (!r) begin
      check("ram_we", ram_we, push_ok);
      check("ram_raddr", ram_raddr, m_rd);
      if (push_ok) begin
        check("ram_waddr", ram_waddr, m_wr);
        check("ram_wdata", ram_wdata, d);
      end
    end
    if (r) begin
      m_count = 0; m_wr = 0; m_rd = 0;
      exp_q.delete();
    end else begin
      if (push_ok) begin
        exp_q.push_back(d);
        m_wr = (m_wr + 1) % DEPTH;
      end
      if (pop_ok) m_rd = (m_rd + 1) % DEPTH;
      if (push_ok && !pop_ok) m_count++;
      if (pop_ok && !push_ok) m_count--;
    end
    @(posedge clk);
    @(negedge clk);
    check("count", bus.count, m_count);
    check("full", bus.full, m_count == DEPTH);
    check("empty", bus.empty, m_count == 0);
    check("almost_full", bus.almost_full, m_count >= AF_LEVEL_DEF);
    check("almost_empty", bus.almost_empty, m_count <= AE_LEVEL_DEF);
    check("overflow", bus.overflow, exp_ovf);
    check("underflow", bus.underflow, exp_unf);
    check("dout_valid", bus.dout_valid, exp_valid);
    if (bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        check("dout_unexpected", 1, 0);
      end else begin
        exp_d = exp_q.pop_front();
        check("dout", bus.dout, exp_d);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.push = 1'b0; bus.din = '0; bus.pop = 1'b0;
    m_count = 0; m_wr = 0; m_rd = 0;
    @(negedge clk);

    // Reset state.
    step(1, 0, 8'h00, 0);

    // Fill with 0x00..0x3F, then a rejected 65th push.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hEE, 0);

    // Drain in order, then a rejected pop.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Wrap with occupancy held at 3.
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 100; i++) step(0, 1, 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);

    // Empty with push and pop together, then pop the pushed word.
    step(0, 1, 8'hA5, 1);
    step(0, 0, 8'h00, 1);

    // Full with push and pop together: pop wins, push overflows.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'($urandom_range(0, 255)), 0);
    step(0, 1, 8'h77, 1);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 8'h00, 1);

    // Reset during a pop with 10 words stored, then a fresh word.
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h10 + i), 0);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
